// File: rtl/mbist_wb_bmaster_if.sv
// Burst-capable Wishbone-style bus between the MBIST burst master and its responder.
interface mbist_wb_bmaster_if;
  logic        wb_stb_o;
  logic [14:0] wb_adr_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [9:0]  wb_bl_o;
  logic        wb_bry_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_lack_i;
  logic        wb_err_i;

  modport master (
    output wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o, wb_bl_o, wb_bry_o,
    input  wb_dat_i, wb_ack_i, wb_lack_i, wb_err_i
  );

  modport slave (
    input  wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o, wb_bl_o, wb_bry_o,
    output wb_dat_i, wb_ack_i, wb_lack_i, wb_err_i
  );
endinterface

// File: rtl/mbist_wb_bmaster.sv
// Burst bus master: runs one write or read burst per command, buffering data through
// a write FIFO and a read FIFO, with per-beat timeout and error reporting.
module mbist_wb_bmaster #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TMO_WD     = 8
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic               cmd_req,
  input  logic               cmd_we,
  input  logic [14:0]        cmd_addr,
  input  logic [9:0]         cmd_bl,
  input  logic [3:0]         cmd_sel,
  output logic               cmd_busy,
  output logic               cmd_done,
  output logic               cmd_err,
  input  logic [31:0]        wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  mbist_wb_bmaster_if.master wb
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  // Last count value before the counter would reach all-ones.
  localparam logic [TMO_WD-1:0] TmoLast = ~TMO_WD'(1);

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst, StFinish} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [14:0]       adr_q, adr_d;
  logic [3:0]        sel_q, sel_d;
  logic [9:0]        bl_q, bl_d;
  logic [9:0]        issued_q, issued_d;
  logic [9:0]        acked_q, acked_d;
  logic [TMO_WD-1:0] tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              alive_q;

  logic [31:0]   wf_mem [FIFO_DEPTH];
  logic [AW-1:0] wf_wptr_q, wf_rptr_q;
  logic [CW-1:0] wf_cnt_q;
  logic [31:0]   rf_mem [FIFO_DEPTH];
  logic [AW-1:0] rf_wptr_q, rf_rptr_q;
  logic [CW-1:0] rf_cnt_q;

  logic          wf_empty, wf_full, wf_push, wf_pop, wf_flush;
  logic          rf_empty, rf_full, rf_push_req, rf_push, rf_pop, rf_ovf;
  logic [CW-1:0] rf_free;
  logic          in_burst, beat_left, bry, beat;

  assign wf_empty  = (wf_cnt_q == '0);
  assign wf_full   = (wf_cnt_q == DepthC);
  assign rf_empty  = (rf_cnt_q == '0);
  assign rf_full   = (rf_cnt_q == DepthC);
  assign rf_free   = DepthC - rf_cnt_q;
  assign in_burst  = (state_q == StWrBurst) || (state_q == StRdBurst);
  assign beat_left = (issued_q < bl_q);

  always_comb begin
    bry = 1'b0;
    unique case (state_q)
      StWrBurst: bry = !wf_empty && beat_left;
      // Two free slots cover the beat already in flight behind the registered ack.
      StRdBurst: bry = beat_left && (rf_free >= CW'(2));
      default:   bry = 1'b0;
    endcase
  end

  assign beat     = in_burst && bry;
  assign wr_ready = alive_q && !wf_full;
  assign wf_push  = wr_valid && wr_ready;
  assign wf_pop   = beat && (state_q == StWrBurst);

  assign rd_valid    = !rf_empty;
  assign rf_pop      = rd_valid && rd_ready;
  assign rf_push_req = (state_q == StRdBurst) && (wb.wb_ack_i || wb.wb_lack_i);
  assign rf_push     = rf_push_req && (!rf_full || rf_pop);
  assign rf_ovf      = rf_push_req && !rf_push;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    bl_d     = bl_q;
    issued_d = issued_q;
    acked_d  = acked_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    wf_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_req) begin
          we_d     = cmd_we;
          adr_d    = cmd_addr;
          sel_d    = cmd_sel;
          bl_d     = (cmd_bl == '0) ? 10'd1 : cmd_bl;
          issued_d = '0;
          acked_d  = '0;
          tmo_d    = '0;
          err_d    = 1'b0;
          state_d  = cmd_we ? StWrBurst : StRdBurst;
        end
      end
      StWrBurst, StRdBurst: begin
        if (beat) issued_d = issued_q + 10'd1;
        if (wb.wb_ack_i) begin
          if (acked_q != '1) acked_d = acked_q + 10'd1;
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (rf_ovf) err_d = 1'b1;
        if (wb.wb_err_i) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else if (wb.wb_lack_i) begin
          if (acked_q + 10'd1 != bl_q) err_d = 1'b1;
          state_d = StFinish;
        end else if (!wb.wb_ack_i && (tmo_q == TmoLast)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: begin
        wf_flush = err_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      bl_q     <= '0;
      issued_q <= '0;
      acked_q  <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      bl_q     <= bl_d;
      issued_q <= issued_d;
      acked_q  <= acked_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      alive_q  <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wf_push) wf_mem[wf_wptr_q] <= wr_data;
    if (rf_push) rf_mem[rf_wptr_q] <= wb.wb_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wf_wptr_q <= '0;
      wf_rptr_q <= '0;
      wf_cnt_q  <= '0;
    end else begin
      if (wf_push) wf_wptr_q <= wf_wptr_q + 1'b1;
      if (wf_flush) begin
        // A push landing in the flush cycle survives as the new head.
        wf_rptr_q <= wf_wptr_q;
        wf_cnt_q  <= wf_push ? CW'(1) : '0;
      end else begin
        if (wf_pop) wf_rptr_q <= wf_rptr_q + 1'b1;
        unique case ({wf_push, wf_pop})
          2'b10:   wf_cnt_q <= wf_cnt_q + 1'b1;
          2'b01:   wf_cnt_q <= wf_cnt_q - 1'b1;
          default: wf_cnt_q <= wf_cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rf_wptr_q <= '0;
      rf_rptr_q <= '0;
      rf_cnt_q  <= '0;
    end else begin
      if (rf_push) rf_wptr_q <= rf_wptr_q + 1'b1;
      if (rf_pop)  rf_rptr_q <= rf_rptr_q + 1'b1;
      unique case ({rf_push, rf_pop})
        2'b10:   rf_cnt_q <= rf_cnt_q + 1'b1;
        2'b01:   rf_cnt_q <= rf_cnt_q - 1'b1;
        default: rf_cnt_q <= rf_cnt_q;
      endcase
    end
  end

  assign rd_data  = rf_empty ? '0 : rf_mem[rf_rptr_q];
  assign cmd_busy = in_burst;
  assign cmd_done = (state_q == StFinish) && !err_q;
  assign cmd_err  = (state_q == StFinish) && err_q;

  assign wb.wb_stb_o = in_burst;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_dat_o = wf_empty ? '0 : wf_mem[wf_rptr_q];
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_bl_o  = bl_q;
  assign wb.wb_bry_o = bry;

endmodule

// File: tb/tb_mbist_wb_bmaster.sv
// Scoreboard bench for mbist_wb_bmaster: directed commands queue their expected bus
// beats, read words and completions; a negedge monitor pops and compares them.
module tb_mbist_wb_bmaster;
  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic        cmd_req, cmd_we, cmd_busy, cmd_done, cmd_err;
  logic [14:0] cmd_addr;
  logic [9:0]  cmd_bl;
  logic [3:0]  cmd_sel;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;

  mbist_wb_bmaster_if wb ();

  mbist_wb_bmaster #(.FIFO_DEPTH(4), .TMO_WD(8)) dut (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .cmd_req  (cmd_req),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_bl   (cmd_bl),
    .cmd_sel  (cmd_sel),
    .cmd_busy (cmd_busy),
    .cmd_done (cmd_done),
    .cmd_err  (cmd_err),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .wb       (wb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_wr_q [$];
  logic [31:0] exp_rd_q [$];
  logic [1:0]  exp_cmp_q [$];  // {done, err}
  logic [14:0] exp_adr;
  int wr_beats   = 0;
  int stb_cycles = 0;

  // Responder: 0 = ack every beat with lack on the last, 1 = silent, 2 = err on beat 2.
  int   rsp_mode = 0;
  int   rsp_bl   = 1;
  int   rsp_n    = 0;
  logic seen_beat = 1'b0;
  logic seen_stb  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_none(input string name, input logic [127:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want nothing", name, act);
  endtask

  always @(negedge wb_clk_i) begin
    seen_beat = wb.wb_stb_o && wb.wb_bry_o;
    seen_stb  = wb.wb_stb_o;
    if (wb.wb_stb_o) stb_cycles++;
    if (wb.wb_stb_o && wb.wb_bry_o && wb.wb_we_o) begin
      wr_beats++;
      if (exp_wr_q.size() == 0) fail_none("wr_beat_extra", wb.wb_dat_o);
      else check("wr_beat_data", wb.wb_dat_o, exp_wr_q.pop_front());
      check("wr_beat_adr", wb.wb_adr_o, exp_adr);
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd_q.size() == 0) fail_none("rd_word_extra", rd_data);
      else check("rd_word", rd_data, exp_rd_q.pop_front());
    end
    if (cmd_done || cmd_err) begin
      if (exp_cmp_q.size() == 0) fail_none("cmd_pulse_extra", {cmd_done, cmd_err});
      else check("cmd_pulse", {cmd_done, cmd_err}, exp_cmp_q.pop_front());
    end
  end

  always @(posedge wb_clk_i) begin
    #1;
    wb.wb_ack_i  = 1'b0;
    wb.wb_lack_i = 1'b0;
    wb.wb_err_i  = 1'b0;
    wb.wb_dat_i  = '0;
    if (!rst_n || !seen_stb) begin
      rsp_n = 0;
    end else if (seen_beat) begin
      if (rsp_mode == 2 && rsp_n == 1) begin
        wb.wb_err_i = 1'b1;
      end else if (rsp_mode != 1) begin
        wb.wb_ack_i  = 1'b1;
        wb.wb_lack_i = (rsp_n + 1 == rsp_bl);
        wb.wb_dat_i  = 32'hD000_0000 + 32'(rsp_n);
      end
      rsp_n++;
    end
  end

  task automatic start_cmd(input logic we, input logic [14:0] addr, input logic [9:0] bl,
                           input logic [3:0] sel);
    @(posedge wb_clk_i); #1;
    cmd_req = 1'b1; cmd_we = we; cmd_addr = addr; cmd_bl = bl; cmd_sel = sel;
    @(posedge wb_clk_i); #1;
    cmd_req = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] d);
    @(posedge wb_clk_i); #1;
    wr_valid = 1'b1; wr_data = d;
    @(posedge wb_clk_i); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge wb_clk_i);
      if (cmd_done || cmd_err) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_none({name, "_timeout"}, cmd_busy);
  endtask

  task automatic all_outputs_zero(input string name);
    check(name, {cmd_busy, cmd_done, cmd_err, wr_ready, rd_valid, rd_data, wb.wb_stb_o,
                 wb.wb_adr_o, wb.wb_we_o, wb.wb_dat_o, wb.wb_sel_o, wb.wb_bl_o,
                 wb.wb_bry_o}, '0);
  endtask

  initial begin
    int b0;
    rst_n = 1'b0; cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_bl = '0; cmd_sel = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; exp_adr = '0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    all_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("ready_after_reset", {wr_ready, rd_valid, cmd_busy}, 3'b100);

    // Four-beat write, data pushed beforehand.
    rsp_mode = 0; rsp_bl = 4; exp_adr = 15'h2000;
    for (int i = 0; i < 4; i++) begin
      exp_wr_q.push_back(32'h1111_1111 * (i + 1));
      push_wr(32'h1111_1111 * (i + 1));
    end
    exp_cmp_q.push_back(2'b10);
    b0 = wr_beats;
    start_cmd(1'b1, 15'h2000, 10'd4, 4'hF);
    @(negedge wb_clk_i);
    check("wr4_latched", {cmd_busy, wb.wb_stb_o, wb.wb_we_o, wb.wb_bl_o, wb.wb_sel_o},
          {3'b111, 10'd4, 4'hF});
    wait_pulse("wr4", 50);
    @(negedge wb_clk_i);
    check("wr4_beats", wr_beats - b0, 4);
    check("wr4_idle", {cmd_busy, wb.wb_stb_o}, 2'b00);

    // Eight-beat read with the consumer stalled.
    rsp_mode = 0; rsp_bl = 8;
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(32'hD000_0000 + 32'(i));
    exp_cmp_q.push_back(2'b10);
    start_cmd(1'b0, 15'h2000, 10'd8, 4'hF);
    repeat (10) @(negedge wb_clk_i);
    check("rd8_stalled", {cmd_busy, wb.wb_stb_o, wb.wb_bry_o, rd_valid}, 4'b1101);
    start_cmd(1'b1, 15'h1234, 10'd2, 4'h3);
    @(negedge wb_clk_i);
    check("busy_req_ignored", {wb.wb_adr_o, wb.wb_we_o, wb.wb_bl_o}, {15'h2000, 1'b0, 10'd8});
    @(posedge wb_clk_i); #1;
    rd_ready = 1'b1;
    wait_pulse("rd8", 100);
    repeat (6) @(negedge wb_clk_i);
    check("rd8_drained", {exp_rd_q.size(), rd_valid}, {32'd0, 1'b0});
    @(posedge wb_clk_i); #1;
    rd_ready = 1'b0;

    // Single-beat register write.
    rsp_mode = 0; rsp_bl = 1; exp_adr = 15'h0004;
    exp_wr_q.push_back(32'hCAFE_F00D);
    push_wr(32'hCAFE_F00D);
    exp_cmp_q.push_back(2'b10);
    b0 = wr_beats;
    start_cmd(1'b1, 15'h0004, 10'd1, 4'hF);
    wait_pulse("reg_wr", 50);
    check("reg_wr_beats", wr_beats - b0, 1);

    // Zero burst length runs as one beat.
    rsp_mode = 0; rsp_bl = 1; exp_adr = 15'h0008;
    exp_wr_q.push_back(32'h0BAD_BEEF);
    push_wr(32'h0BAD_BEEF);
    exp_cmp_q.push_back(2'b10);
    b0 = wr_beats;
    start_cmd(1'b1, 15'h0008, 10'd0, 4'h1);
    @(negedge wb_clk_i);
    check("bl0_as_1", wb.wb_bl_o, 10'd1);
    wait_pulse("bl0", 50);
    check("bl0_beats", wr_beats - b0, 1);

    // Silent responder: timeout after 255 strobe cycles.
    rsp_mode = 1; rsp_bl = 3; exp_adr = 15'h0010;
    exp_wr_q.push_back(32'h5A5A_0001);
    push_wr(32'h5A5A_0001);
    exp_cmp_q.push_back(2'b01);
    b0 = stb_cycles;
    start_cmd(1'b1, 15'h0010, 10'd3, 4'hF);
    wait_pulse("tmo", 400);
    @(negedge wb_clk_i);
    check("tmo_stb_cycles", stb_cycles - b0, 255);
    check("tmo_wfifo_empty", {wb.wb_dat_o, wr_ready}, {32'h0, 1'b1});

    // Error mid-write flushes the leftover word.
    rsp_mode = 2; rsp_bl = 2; exp_adr = 15'h0020;
    for (int i = 0; i < 3; i++) push_wr(32'h7700_0000 + 32'(i));
    exp_wr_q.push_back(32'h7700_0000);
    exp_wr_q.push_back(32'h7700_0001);
    exp_cmp_q.push_back(2'b01);
    start_cmd(1'b1, 15'h0020, 10'd2, 4'hF);
    wait_pulse("wr_err", 50);
    @(negedge wb_clk_i);
    check("wr_err_flushed", wb.wb_dat_o, 32'h0);

    // Error on beat 2 of a four-beat read.
    rsp_mode = 2; rsp_bl = 4;
    exp_rd_q.push_back(32'hD000_0000);
    exp_cmp_q.push_back(2'b01);
    start_cmd(1'b0, 15'h0040, 10'd4, 4'hF);
    wait_pulse("rd_err", 50);
    check("rd_err_stb_low", {wb.wb_stb_o, rd_valid}, 2'b01);
    @(posedge wb_clk_i); #1;
    rd_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    rd_ready = 1'b0;
    @(negedge wb_clk_i);
    check("rd_err_one_word", {exp_rd_q.size(), rd_valid}, {32'd0, 1'b0});

    // Reset in the middle of a read.
    rsp_mode = 0; rsp_bl = 8;
    start_cmd(1'b0, 15'h2000, 10'd8, 4'hF);
    repeat (3) @(posedge wb_clk_i);
    #1 rst_n = 1'b0;
    @(negedge wb_clk_i);
    all_outputs_zero("midreset_outputs");
    repeat (2) @(posedge wb_clk_i);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("post_reset_idle", {cmd_busy, rd_valid, wr_ready}, 3'b001);

    rsp_mode = 0; rsp_bl = 1; exp_adr = 15'h0004;
    exp_wr_q.push_back(32'h1357_9BDF);
    push_wr(32'h1357_9BDF);
    exp_cmp_q.push_back(2'b10);
    start_cmd(1'b1, 15'h0004, 10'd1, 4'hF);
    wait_pulse("post_reset_cmd", 50);

    repeat (5) @(negedge wb_clk_i);
    check("queues_drained", {exp_wr_q.size(), exp_rd_q.size(), exp_cmp_q.size()}, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mbist_wb_bmaster.md
MBIST_WB_BMASTER -- requirements
Module: mbist_wb_bmaster

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the entry count of each of the write and read data FIFOs (power of 2, >=4).
REQ-002 SHALL have parameter TMO_WD, default 8, meaning the width of the per-beat timeout counter.
REQ-003 SHALL have ports, one per line (clock and reset first):
  wb_clk_i  in  1  clock; all logic on its rising edge
  rst_n  in  1  reset, asynchronous, active-low
  cmd_req  in  1  start command pulse; sampled in IDLE only
  cmd_we  in  1  1=write burst, 0=read burst
  cmd_addr  in  15  byte address
  cmd_bl  in  10  burst length in beats, 1..1023
  cmd_sel  in  4  byte enables
  cmd_busy  out  1  command in progress
  cmd_done  out  1  one-cycle pulse at normal completion
  cmd_err  out  1  one-cycle pulse at error or timeout completion
  wr_data  in  32  write beat data
  wr_valid  in  1  write FIFO push request
  wr_ready  out  1  write FIFO not full
  rd_data  out  32  read FIFO head
  rd_valid  out  1  read FIFO not empty
  rd_ready  in  1  read FIFO pop
  wb_stb_o  out  1  strobe
  wb_adr_o  out  15  address
  wb_we_o  out  1  write
  wb_dat_o  out  32  write data
  wb_sel_o  out  4  byte enables
  wb_bl_o  out  10  burst length
  wb_bry_o  out  1  burst ready; one beat offered per high cycle
  wb_dat_i  in  32  read data
  wb_ack_i  in  1  beat acknowledge
  wb_lack_i  in  1  last-beat acknowledge
  wb_err_i  in  1  error

Function
REQ-004 SHALL implement states IDLE, WR_BURST, RD_BURST, and FINISH.
REQ-005 IDLE: on cmd_req, SHALL latch cmd_we, cmd_addr, cmd_bl, and cmd_sel into wb_we_o, wb_adr_o, wb_bl_o, and wb_sel_o; clear beat counters; raise wb_stb_o and cmd_busy next cycle; go to WR_BURST or RD_BURST.
REQ-006 SHALL ignore cmd_req while cmd_busy is 1.
REQ-007 SHALL treat cmd_bl=0 as 1.
REQ-008 SHALL hold wb_adr_o, wb_we_o, wb_sel_o, and wb_bl_o stable while wb_stb_o is 1.
REQ-009 Write FIFO: SHALL push wr_data when wr_valid and wr_ready are both 1; wr_ready = not full; a push is allowed in any state.
REQ-010 WR_BURST: SHALL drive wb_bry_o = write FIFO not empty AND issued count < bl.
REQ-011 In WR_BURST, wb_dat_o SHALL equal the write FIFO head combinationally.
REQ-012 In WR_BURST, each cycle with wb_stb_o and wb_bry_o both 1 SHALL pop one entry and increment the issued count (10-bit).
REQ-013 In WR_BURST, wb_ack_i SHALL increment the acknowledged count.
REQ-014 In WR_BURST, wb_lack_i SHALL go to FINISH.
REQ-015 RD_BURST: SHALL drive wb_bry_o = issued count < bl AND read FIFO free entries >= 2 (this absorbs the one-cycle registered-ack latency).
REQ-016 In RD_BURST, each wb_ack_i SHALL push wb_dat_i into the read FIFO and increment the acknowledged count.
REQ-017 In RD_BURST, wb_lack_i SHALL push its data and then go to FINISH.
REQ-018 Read FIFO: rd_valid = not empty; rd_data = head; SHALL pop when rd_valid and rd_ready are both 1.
REQ-019 Simultaneous read-FIFO push and pop SHALL leave the count unchanged.
REQ-020 A read-FIFO push while full SHALL be dropped and SHALL force the error flag.
REQ-021 wb_err_i SHALL go to FINISH with the error flag set.
REQ-022 Timeout counter: SHALL reset on each wb_ack_i; SHALL increment while wb_stb_o is 1; at all-ones SHALL go to FINISH with the error flag set.
REQ-023 A wb_lack_i received with acknowledged count+1 != bl SHALL set the error flag.
REQ-024 FINISH: SHALL drop wb_stb_o and wb_bry_o; pulse cmd_done (flag clear) or cmd_err (flag set) for one cycle; clear cmd_busy; return to IDLE.
REQ-025 Leftover write-FIFO entries after an error SHALL be flushed in FINISH.
REQ-026 Read-FIFO contents SHALL be preserved across FINISH.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Beat counters SHALL NOT wrap (bl <= 1023).

Reset
REQ-029 While rst_n is 0, SHALL drive all outputs to 0 (wb_dat_o=0 and rd_data=0 because the FIFOs are empty), empty both FIFOs, clear the counters and error flag, and force state IDLE.
REQ-030 Reset asserted mid-burst SHALL abort immediately with no cmd_done/cmd_err pulse.

Verification
REQ-031 Write with cmd_addr=0x2000, bl=4, four words pushed beforehand -> exactly four stb&bry cycles carrying the words in order; lack on 4th ack; cmd_done pulse once; cmd_busy low afterward.
REQ-032 Read with addr=0x2000, bl=8, rd_ready held 0 -> bry drops once the FIFO is at 3 entries; no overflow; releasing rd_ready delivers 8 words in order with cmd_done.
REQ-033 Register write with addr=0x0004, bl=1, sel=0xF -> a single bry beat; responder ack+lack -> cmd_done.
REQ-034 Write with bl=3 and only 1 word pushed, responder silent -> cmd_err after 255 stb cycles without ack; write FIFO empty.
REQ-035 wb_err_i during beat 2 of a read with bl=4 -> cmd_err pulse; stb low next cycle; 1 word in the read FIFO.
REQ-036 rst_n pulsed low mid-read -> all outputs 0, rd_valid 0, no cmd_done; a new command then completes normally.
